traffic_ctrl_param: RTL and testbench

Parametrised successor to the fixed-count intersection controller. One car signal head and one pedestrian head are sequenced through a phase state machine. Phase durations, tick prescaling and the left-turn phase are configurable. In demand mode, a pedestrian request/acknowledge handshake decides whether the walk phase is served. The block sits between the board-level start/mode inputs and the lamp drivers.

---
 rtl/traffic_ctrl_param_if.sv | 32 +++
 rtl/traffic_ctrl_param.sv | 194 +++++++++++++++++++
 tb/tb_traffic_ctrl_param.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_ctrl_param_if.sv
// Bundles the board-side controls and lamp-driver outputs of the intersection controller.
// Latency: pure wiring, no storage.
// Backpressure: none; every signal is a level and is valid on every clock.
//
// Signals:
//   i_start          run (1) / dark and held at cycle start (0)
//   i_flag           reset-time start point: 1 = GREEN, 0 = last tick of YEL2
//   i_ped_req        pedestrian request level
//   o_car_traffic    one-hot car head: RED 1000, YELLOW 0100, LEFT 0010, GREEN 0001
//   o_walker_traffic walker head: RED 10, GREEN 01, NONE 00
//   o_phase          current phase code (0..6)
//   o_ped_ack        one-clock pulse on the first clock of WALK
interface traffic_ctrl_param_if;
    logic       i_start;
    logic       i_flag;
    logic       i_ped_req;
    logic [3:0] o_car_traffic;
    logic [1:0] o_walker_traffic;
    logic [2:0] o_phase;
    logic       o_ped_ack;

    // master drives the controls (board / bench), slave is the controller
    modport master (
        output i_start, i_flag, i_ped_req,
        input  o_car_traffic, o_walker_traffic, o_phase, o_ped_ack
    );

    modport slave (
        input  i_start, i_flag, i_ped_req,
        output o_car_traffic, o_walker_traffic, o_phase, o_ped_ack
    );
endinterface

// File: rtl/traffic_ctrl_param.sv
// Parametrised car/pedestrian signal sequencer with optional left-turn and demand-driven walk phase.
// Latency: lamp outputs change on the same edge as the phase state; i_start gates them combinationally.
// Backpressure: none; the pedestrian request is latched and served on the next eligible cycle.
//
// Ports:
//   clk      system clock, all state on the rising edge
//   reset_n  synchronous active-low reset (wins over i_start)
//   bus      traffic_ctrl_param_if.slave: i_start, i_flag, i_ped_req in;
//            o_car_traffic, o_walker_traffic, o_phase, o_ped_ack out
module traffic_ctrl_param #(
    parameter int TICK_DIV   = 1,
    parameter int GREEN_T    = 21,
    parameter int YEL_T      = 2,
    parameter int LEFT_T     = 10,
    parameter int WALK_T     = 14,
    parameter int BLINK_T    = 6,
    parameter int ALLRED_T   = 14,
    parameter int LEFT_EN    = 1,
    parameter int PED_DEMAND = 0,
    parameter int CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    traffic_ctrl_param_if.slave  bus
);

    typedef enum logic [2:0] {
        PH_GREEN  = 3'd0,
        PH_YEL1   = 3'd1,
        PH_LEFT   = 3'd2,
        PH_YEL2   = 3'd3,
        PH_WALK   = 3'd4,
        PH_BLINK  = 3'd5,
        PH_ALLRED = 3'd6
    } phase_e;

    localparam logic [3:0] CAR_RED   = 4'b1000;
    localparam logic [3:0] CAR_YEL   = 4'b0100;
    localparam logic [3:0] CAR_LEFT  = 4'b0010;
    localparam logic [3:0] CAR_GREEN = 4'b0001;
    localparam logic [3:0] CAR_NONE  = 4'b0000;

    localparam logic [1:0] WLK_RED   = 2'b10;
    localparam logic [1:0] WLK_GREEN = 2'b01;
    localparam logic [1:0] WLK_NONE  = 2'b00;

    // Terminal counts: each counter runs 0..N-1
    localparam logic [CNT_W-1:0] DIV_LAST    = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_T - 1);
    localparam logic [CNT_W-1:0] YEL_LAST    = CNT_W'(YEL_T - 1);
    localparam logic [CNT_W-1:0] LEFT_LAST   = CNT_W'(LEFT_T - 1);
    localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_T - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST  = CNT_W'(BLINK_T - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    // Registered state
    phase_e           phase;
    logic [CNT_W-1:0] presc;
    logic [CNT_W-1:0] phase_cnt;
    logic             ped_pending;
    logic [3:0]       car_q;
    logic [1:0]       walk_q;
    logic             ack_q;

    // Next-state terms for the running (i_start=1) case
    phase_e           phase_adv;
    phase_e           phase_nxt;
    logic [CNT_W-1:0] presc_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_last;
    logic             pend_nxt;
    logic             tick;
    logic             phase_end;
    logic             walk_entry;
    logic             ped_set;

    function automatic logic [3:0] car_decode(input phase_e ph);
        logic [3:0] v;
        case (ph)
            PH_GREEN:         v = CAR_GREEN;
            PH_YEL1, PH_YEL2: v = CAR_YEL;
            PH_LEFT:          v = CAR_LEFT;
            default:          v = CAR_RED;
        endcase
        return v;
    endfunction

    // BLINK flashes the walk lamp: dark on even ticks, lit on odd ticks
    function automatic logic [1:0] walk_decode(input phase_e ph, input logic cnt_odd);
        logic [1:0] v;
        case (ph)
            PH_WALK:  v = WLK_GREEN;
            PH_BLINK: v = cnt_odd ? WLK_GREEN : WLK_NONE;
            default:  v = WLK_RED;
        endcase
        return v;
    endfunction

    always_comb begin
        cnt_last = ALLRED_LAST;
        case (phase)
            PH_GREEN:         cnt_last = GREEN_LAST;
            PH_YEL1, PH_YEL2: cnt_last = YEL_LAST;
            PH_LEFT:          cnt_last = LEFT_LAST;
            PH_WALK:          cnt_last = WALK_LAST;
            PH_BLINK:         cnt_last = BLINK_LAST;
            default:          cnt_last = ALLRED_LAST;
        endcase
    end

    // Successor phase; the walk skip looks at the request latched before this clock
    always_comb begin
        phase_adv = PH_GREEN;
        case (phase)
            PH_GREEN:  phase_adv = (LEFT_EN != 0) ? PH_YEL1 : PH_YEL2;
            PH_YEL1:   phase_adv = PH_LEFT;
            PH_LEFT:   phase_adv = PH_YEL2;
            PH_YEL2:   phase_adv = ((PED_DEMAND != 0) && !ped_pending) ? PH_ALLRED : PH_WALK;
            PH_WALK:   phase_adv = PH_BLINK;
            PH_BLINK:  phase_adv = PH_ALLRED;
            default:   phase_adv = PH_GREEN;
        endcase
    end

    assign tick      = (presc == DIV_LAST);
    assign phase_end = tick && (phase_cnt == cnt_last);
    assign ped_set   = bus.i_start && bus.i_ped_req &&
                       (phase != PH_WALK) && (phase != PH_BLINK);

    // Running / dark next state; reset is handled in the register block
    always_comb begin
        phase_nxt  = PH_GREEN;
        presc_nxt  = '0;
        cnt_nxt    = '0;
        pend_nxt   = 1'b0;
        walk_entry = 1'b0;
        if (bus.i_start) begin
            presc_nxt = tick ? '0 : presc + CNT_ONE;
            phase_nxt = phase;
            cnt_nxt   = phase_cnt;
            if (phase_end) begin
                phase_nxt = phase_adv;
                cnt_nxt   = '0;
            end else if (tick) begin
                cnt_nxt = phase_cnt + CNT_ONE;
            end
            walk_entry = phase_end && (phase_adv == PH_WALK);
            // Clearing on WALK entry takes precedence over a same-clock request
            if (walk_entry) begin
                pend_nxt = 1'b0;
            end else begin
                pend_nxt = ped_pending || ped_set;
            end
        end
    end

    // Lamp decodes are registered alongside the state they describe, so they
    // always match the phase register with no extra latency.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            presc       <= '0;
            ped_pending <= 1'b0;
            ack_q       <= 1'b0;
            if (bus.i_flag) begin
                phase     <= PH_GREEN;
                phase_cnt <= '0;
                car_q     <= car_decode(PH_GREEN);
                walk_q    <= walk_decode(PH_GREEN, 1'b0);
            end else begin
                // Last tick of YEL2: the very next tick enters the pedestrian phases
                phase     <= PH_YEL2;
                phase_cnt <= YEL_LAST;
                car_q     <= car_decode(PH_YEL2);
                walk_q    <= walk_decode(PH_YEL2, YEL_LAST[0]);
            end
        end else begin
            phase       <= phase_nxt;
            presc       <= presc_nxt;
            phase_cnt   <= cnt_nxt;
            ped_pending <= pend_nxt;
            car_q       <= car_decode(phase_nxt);
            walk_q      <= walk_decode(phase_nxt, cnt_nxt[0]);
            ack_q       <= walk_entry;
        end
    end

    // i_start=0 blanks both heads immediately; o_phase shows the raw phase register
    assign bus.o_car_traffic    = bus.i_start ? car_q : CAR_NONE;
    assign bus.o_walker_traffic = bus.i_start ? walk_q : WLK_NONE;
    assign bus.o_ped_ack        = bus.i_start && ack_q;
    assign bus.o_phase          = phase;

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Bench for traffic_ctrl_param: three configurations driven with shared stimulus.
// Latency: outputs sampled 2 time units after each rising edge.
// Backpressure: not applicable.
module tb_traffic_ctrl_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, start, flag, req;
    int   checks = 0;
    int   errors = 0;

    traffic_ctrl_param_if bus_a ();
    traffic_ctrl_param_if bus_b ();
    traffic_ctrl_param_if bus_c ();

    assign bus_a.i_start = start;  assign bus_a.i_flag = flag;  assign bus_a.i_ped_req = req;
    assign bus_b.i_start = start;  assign bus_b.i_flag = flag;  assign bus_b.i_ped_req = req;
    assign bus_c.i_start = start;  assign bus_c.i_flag = flag;  assign bus_c.i_ped_req = req;

    // A: defaults. B: demand mode, short odd timings. C: slow ticks, no left turn.
    traffic_ctrl_param dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a.slave));

    traffic_ctrl_param #(
        .TICK_DIV(2), .GREEN_T(5), .YEL_T(1), .LEFT_T(3), .WALK_T(4),
        .BLINK_T(5), .ALLRED_T(2), .LEFT_EN(1), .PED_DEMAND(1), .CNT_W(8)
    ) dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b.slave));

    traffic_ctrl_param #(
        .TICK_DIV(4), .LEFT_EN(0)
    ) dut_c (.clk(clk), .reset_n(reset_n), .bus(bus_c.slave));

    logic [3:0] car_o  [3];
    logic [1:0] walk_o [3];
    logic [2:0] ph_o   [3];
    logic       ack_o  [3];

    assign car_o[0] = bus_a.o_car_traffic;  assign walk_o[0] = bus_a.o_walker_traffic;
    assign ph_o[0]  = bus_a.o_phase;        assign ack_o[0]  = bus_a.o_ped_ack;
    assign car_o[1] = bus_b.o_car_traffic;  assign walk_o[1] = bus_b.o_walker_traffic;
    assign ph_o[1]  = bus_b.o_phase;        assign ack_o[1]  = bus_b.o_ped_ack;
    assign car_o[2] = bus_c.o_car_traffic;  assign walk_o[2] = bus_c.o_walker_traffic;
    assign ph_o[2]  = bus_c.o_phase;        assign ack_o[2]  = bus_c.o_ped_ack;

    // Reference configuration; durations indexed by phase code 0..6
    int div_c  [3] = '{1, 2, 4};
    int left_c [3] = '{1, 1, 0};
    int dem_c  [3] = '{0, 1, 0};
    int dur_c  [3][7] = '{'{21, 2, 10, 2, 14, 6, 14},
                          '{ 5, 1,  3, 1,  4, 5,  2},
                          '{21, 2, 10, 2, 14, 6, 14}};

    // Reference state: phase code, clocks spent in it, latched request
    int m_ph   [3];
    int m_el   [3];
    bit m_pend [3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int next_ph(input int k, input int ph, input bit pend);
        case (ph)
            0:       return (left_c[k] != 0) ? 1 : 3;
            3:       return (dem_c[k] != 0 && !pend) ? 6 : 4;
            6:       return 0;
            default: return ph + 1;
        endcase
    endfunction

    task automatic model_step();
        bit set_p;
        for (int k = 0; k < 3; k++) begin
            if (!reset_n) begin
                m_pend[k] = 1'b0;
                if (flag) begin
                    m_ph[k] = 0;
                    m_el[k] = 0;
                end else begin
                    m_ph[k] = 3;
                    m_el[k] = (dur_c[k][3] - 1) * div_c[k];
                end
            end else if (!start) begin
                m_ph[k] = 0; m_el[k] = 0; m_pend[k] = 1'b0;
            end else begin
                set_p = req && m_ph[k] != 4 && m_ph[k] != 5;
                if (m_el[k] + 1 == dur_c[k][m_ph[k]] * div_c[k]) begin
                    m_ph[k] = next_ph(k, m_ph[k], m_pend[k]);
                    m_el[k] = 0;
                end else begin
                    m_el[k]++;
                end
                if (m_ph[k] == 4 && m_el[k] == 0) m_pend[k] = 1'b0;
                else if (set_p)                   m_pend[k] = 1'b1;
            end
        end
    endtask

    task automatic model_check();
        logic [3:0] ec;
        logic [1:0] ew;
        for (int k = 0; k < 3; k++) begin
            case (m_ph[k])
                0:       ec = 4'b0001;
                1, 3:    ec = 4'b0100;
                2:       ec = 4'b0010;
                default: ec = 4'b1000;
            endcase
            if (m_ph[k] == 4)      ew = 2'b01;
            else if (m_ph[k] == 5) ew = ((m_el[k] / div_c[k]) % 2 == 1) ? 2'b01 : 2'b00;
            else                   ew = 2'b10;
            if (!start) begin ec = 4'b0000; ew = 2'b00; end
            check($sformatf("car_%0d", k),   car_o[k],  ec);
            check($sformatf("walk_%0d", k),  walk_o[k], ew);
            check($sformatf("phase_%0d", k), ph_o[k],   m_ph[k]);
            check($sformatf("ack_%0d", k),   ack_o[k],  start && m_ph[k] == 4 && m_el[k] == 0);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        settle();
        model_check();
        advance();
    endtask

    logic [3:0] exp_car_a [$];
    logic [1:0] exp_walk_a[$];
    logic [3:0] exp_car_c [$];
    int         drop;

    initial begin
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 21; i++) exp_car_a.push_back(4'b0001);
            for (int i = 0; i < 2;  i++) exp_car_a.push_back(4'b0100);
            for (int i = 0; i < 10; i++) exp_car_a.push_back(4'b0010);
            for (int i = 0; i < 2;  i++) exp_car_a.push_back(4'b0100);
            for (int i = 0; i < 34; i++) exp_car_a.push_back(4'b1000);
            for (int i = 0; i < 35; i++) exp_walk_a.push_back(2'b10);
            for (int i = 0; i < 14; i++) exp_walk_a.push_back(2'b01);
            for (int i = 0; i < 6;  i++) exp_walk_a.push_back((i % 2 == 1) ? 2'b01 : 2'b00);
            for (int i = 0; i < 14; i++) exp_walk_a.push_back(2'b10);
        end
        for (int i = 0; i < 84; i++) exp_car_c.push_back(4'b0001);
        for (int i = 0; i < 8;  i++) exp_car_c.push_back(4'b0100);
        for (int i = 0; i < 46; i++) exp_car_c.push_back(4'b1000);

        // Reset with i_flag=1, held dark
        reset_n = 1'b0; start = 1'b0; flag = 1'b1; req = 1'b0;
        advance();
        advance();
        settle();
        model_check();
        check("rst_car", car_o[0], 4'b0000);
        check("rst_walk", walk_o[0], 2'b00);
        check("rst_phase", ph_o[0], 3'd0);
        advance();

        // Two full default cycles from GREEN
        reset_n = 1'b1; start = 1'b1;
        for (int i = 0; i < 138; i++) begin
            settle();
            model_check();
            check("dir_car_a", car_o[0], exp_car_a[i]);
            check("dir_walk_a", walk_o[0], exp_walk_a[i]);
            check("dir_ack_a", ack_o[0], (i == 35 || i == 104));
            check("dir_car_c", car_o[2], exp_car_c[i]);
            advance();
        end

        // Reset with i_flag=0: one YELLOW clock, then WALK with a single ack
        reset_n = 1'b0; flag = 1'b0;
        advance();
        reset_n = 1'b1;
        settle();
        model_check();
        check("flag0_car", car_o[0], 4'b0100);
        check("flag0_walk", walk_o[0], 2'b10);
        advance();
        settle();
        model_check();
        check("flag0_car2", car_o[0], 4'b1000);
        check("flag0_walk2", walk_o[0], 2'b01);
        check("flag0_ack", ack_o[0], 1'b1);
        advance();
        settle();
        model_check();
        check("flag0_ack_end", ack_o[0], 1'b0);
        advance();

        // Drop i_start mid-LEFT for 3 clocks, then GREEN must last a full 21
        reset_n = 1'b0; flag = 1'b1;
        advance();
        reset_n = 1'b1;
        for (int i = 0; i < 26; i++) step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            model_check();
            check("drop_car", car_o[0], 4'b0000);
            check("drop_walk", walk_o[0], 2'b00);
            advance();
        end
        start = 1'b1;
        for (int i = 0; i < 22; i++) begin
            settle();
            model_check();
            check("regreen_car", car_o[0], (i < 21) ? 4'b0001 : 4'b0100);
            advance();
        end

        // Randomised run, with a window of a permanently held request
        drop = 0;
        for (int i = 0; i < 3000; i++) begin
            reset_n = ($urandom_range(0, 599) != 0);
            flag    = 1'($urandom_range(0, 1));
            if (drop > 0) begin
                start = 1'b0;
                drop--;
            end else begin
                start = 1'b1;
                if ($urandom_range(0, 79) == 0) drop = $urandom_range(1, 4);
            end
            if (i >= 1500 && i < 1800) req = 1'b1;
            else                       req = ($urandom_range(0, 39) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
